// File: rtl/nat_pkg.sv
// Shared constants, 5-tuple layout, hash and FSM states
// for the NAT connection table.
package nat_pkg;

    localparam int HASH_LEN = 6;
    localparam int KEY_W    = 104;

    // {src_ip, dst_ip, src_port, dst_port, proto}, MSB first
    localparam int OFS_SRC_IP   = 72;
    localparam int OFS_DST_IP   = 40;
    localparam int OFS_SRC_PORT = 24;
    localparam int OFS_DST_PORT = 8;
    localparam int OFS_PROTO    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_CLEAR
    } state_t;

    function automatic logic [HASH_LEN-1:0] nat_hash(
        input logic [KEY_W-1:0] key
    );
        return key[OFS_SRC_IP   +: HASH_LEN]
             ^ key[OFS_DST_IP   +: HASH_LEN]
             ^ key[OFS_SRC_PORT +: HASH_LEN]
             ^ key[OFS_DST_PORT +: HASH_LEN]
             ^ key[OFS_PROTO    +: HASH_LEN];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester
// after the last winner; pointer moves on every grant.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [PW-1:0]    o_idx
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = r_ptr;
        w_cand  = r_ptr;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = PW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (i_en && w_found) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (|o_gnt) begin
            r_ptr <= o_idx;
        end
    end

endmodule

// File: rtl/conn_table_sched.sv
// NAT connection table: round-robin lookup-or-insert with
// hash + linear probe, plus a sequenced full-table flush.
module conn_table_sched #(
    parameter int HASH_LEN = nat_pkg::HASH_LEN,
    parameter int N_REQ    = 2,
    parameter int KEY_W    = nat_pkg::KEY_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*KEY_W-1:0] req_key,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [HASH_LEN-1:0]    rsp_idx,
    output logic                   rsp_hit,
    output logic                   rsp_full,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic [HASH_LEN:0]      n_conn
);

    import nat_pkg::*;

    localparam int ID_SPACE = 1 << HASH_LEN;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                r_state;
    state_t                w_state_nx;
    logic [KEY_W-1:0]      r_key;
    logic [HASH_LEN-1:0]   r_slot;
    logic [HASH_LEN-1:0]   r_probes;
    logic [PW-1:0]         r_req;
    logic [HASH_LEN-1:0]   r_next_id;
    logic [HASH_LEN:0]     r_n_conn;
    logic                  r_clr_pend;
    logic [HASH_LEN-1:0]   r_rsp_idx;
    logic                  r_rsp_hit;
    logic                  r_rsp_full;

    logic [ID_SPACE-1:0]   r_tab_vld;
    logic [KEY_W-1:0]      r_tab_key [ID_SPACE];
    logic [HASH_LEN-1:0]   r_tab_id  [ID_SPACE];

    logic [N_REQ-1:0]      w_gnt;
    logic [PW-1:0]         w_gidx;
    logic [KEY_W-1:0]      w_gkey;
    logic                  w_clr_any;
    logic                  w_arb_en;
    logic                  w_hit;
    logic                  w_free;
    logic                  w_last;
    logic                  w_clr_last;
    logic                  w_done;
    logic                  w_ins;
    logic [HASH_LEN-1:0]   w_rsp_idx;
    logic                  w_rsp_hit;
    logic                  w_rsp_full;

    assign w_clr_any  = r_clr_pend | clr_req;
    assign w_arb_en   = (r_state == ST_IDLE) && !w_clr_any;
    assign w_hit      = r_tab_vld[r_slot] && (r_tab_key[r_slot] == r_key);
    assign w_free     = !r_tab_vld[r_slot] &&
                        (r_n_conn < (HASH_LEN+1)'(ID_SPACE));
    assign w_last     = r_probes == HASH_LEN'(ID_SPACE - 1);
    assign w_clr_last = r_slot == HASH_LEN'(ID_SPACE - 1);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_arb_en),
        .i_req (req_valid),
        .o_gnt (w_gnt),
        .o_idx (w_gidx)
    );

    always_comb begin
        w_gkey = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gidx == PW'(i)) begin
                w_gkey = req_key[i*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
        w_ins      = 1'b0;
        w_rsp_idx  = r_rsp_idx;
        w_rsp_hit  = r_rsp_hit;
        w_rsp_full = r_rsp_full;
        unique case (r_state)
            ST_IDLE: begin
                if (w_clr_any) begin
                    w_state_nx = ST_CLEAR;
                end else if (|w_gnt) begin
                    w_state_nx = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (w_hit) begin
                    w_done     = 1'b1;
                    w_rsp_idx  = r_tab_id[r_slot];
                    w_rsp_hit  = 1'b1;
                    w_rsp_full = 1'b0;
                end else if (w_free) begin
                    w_done     = 1'b1;
                    w_ins      = 1'b1;
                    w_rsp_idx  = r_next_id;
                    w_rsp_hit  = 1'b0;
                    w_rsp_full = 1'b0;
                end else if (w_last) begin
                    w_done     = 1'b1;
                    w_rsp_idx  = '0;
                    w_rsp_hit  = 1'b0;
                    w_rsp_full = 1'b1;
                end
                if (w_done) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key      <= '0;
            r_slot     <= '0;
            r_probes   <= '0;
            r_req      <= '0;
            r_next_id  <= '0;
            r_n_conn   <= '0;
            r_clr_pend <= 1'b0;
            r_tab_vld  <= '0;
            r_rsp_idx  <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_full <= 1'b0;
        end else begin
            r_rsp_idx  <= w_rsp_idx;
            r_rsp_hit  <= w_rsp_hit;
            r_rsp_full <= w_rsp_full;
            unique case (r_state)
                ST_IDLE: begin
                    r_clr_pend <= 1'b0;
                    if (w_clr_any) begin
                        r_slot <= '0;
                    end else if (|w_gnt) begin
                        r_key    <= w_gkey;
                        r_slot   <= nat_hash(w_gkey);
                        r_probes <= '0;
                        r_req    <= w_gidx;
                    end
                end
                ST_PROBE: begin
                    // a flush requested mid-probe waits for this lookup
                    if (clr_req) begin
                        r_clr_pend <= 1'b1;
                    end
                    if (w_ins) begin
                        r_tab_vld[r_slot] <= 1'b1;
                        r_next_id <= r_next_id + 1'b1;
                        r_n_conn  <= r_n_conn + 1'b1;
                    end else if (!w_done) begin
                        r_slot   <= r_slot + 1'b1;
                        r_probes <= r_probes + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_tab_vld[r_slot] <= 1'b0;
                    r_slot <= r_slot + 1'b1;
                    if (w_clr_last) begin
                        r_next_id <= '0;
                        r_n_conn  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ins) begin
            r_tab_key[r_slot] <= r_key;
            r_tab_id[r_slot]  <= r_next_id;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (w_done) begin
            rsp_valid[r_req] = 1'b1;
        end
    end

    assign req_ready = w_gnt;
    assign rsp_idx   = w_rsp_idx;
    assign rsp_hit   = w_rsp_hit;
    assign rsp_full  = w_rsp_full;
    assign clr_busy  = w_clr_any | (r_state == ST_CLEAR);
    assign n_conn    = r_n_conn;

endmodule

// File: tb/tb_conn_table_sched.sv
// Directed bench for conn_table_sched: vector table for
// lookup/insert/collision plus hand sequences for the corners.
module tb_conn_table_sched;

    localparam int HL = 6;
    localparam int NR = 2;
    localparam int KW = 104;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*KW-1:0] req_key = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [HL-1:0]    rsp_idx;
    logic             rsp_hit;
    logic             rsp_full;
    logic             clr_req = 1'b0;
    logic             clr_busy;
    logic [HL:0]      n_conn;

    conn_table_sched #(
        .HASH_LEN (HL),
        .N_REQ    (NR),
        .KEY_W    (KW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_key   (req_key),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_idx   (rsp_idx),
        .rsp_hit   (rsp_hit),
        .rsp_full  (rsp_full),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .n_conn    (n_conn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rq;
        logic [KW-1:0] key;
        logic        hit;
        logic [HL-1:0] idx;
        int          lat;
        logic [HL:0] nc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    vec_t          vt [6];
    int            lat;
    logic          hit;
    logic [HL-1:0] idx;
    logic          full;
    logic [HL:0]   nc;
    logic [NR-1:0] rv;
    logic [NR-1:0] g;
    logic          gseq [8];
    int            ng;
    int            nk;
    int            n;
    logic [KW-1:0] kA, kB, kC, kD;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] mk(input logic [31:0] s,
                                         input logic [31:0] d,
                                         input logic [15:0] sp,
                                         input logic [15:0] dp,
                                         input logic [7:0] pr);
        return {s, d, sp, dp, pr};
    endfunction

    task automatic send(input int rq, input logic [KW-1:0] key,
                        output int lat_o, output logic hit_o,
                        output logic [HL-1:0] idx_o, output logic full_o,
                        output logic [HL:0] nc_o, output logic [NR-1:0] rv_o);
        int w;
        lat_o = -1;
        hit_o = 1'bx;
        idx_o = 'x;
        full_o = 1'bx;
        rv_o = 'x;
        @(negedge clk);
        req_valid = '0;
        req_valid[rq] = 1'b1;
        req_key = '0;
        req_key[rq*KW +: KW] = key;
        #1;
        w = 0;
        while (!req_ready[rq] && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (req_ready[rq]) begin
            @(posedge clk);
            #1;
            req_valid = '0;
            w = 0;
            while (w < 300) begin
                @(negedge clk);
                w++;
                if (rsp_valid != '0) begin
                    lat_o = w;
                    hit_o = rsp_hit;
                    idx_o = rsp_idx;
                    full_o = rsp_full;
                    rv_o = rsp_valid;
                    break;
                end
            end
        end
        req_valid = '0;
        @(negedge clk);
        nc_o = n_conn;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        kA = mk(32'h0a000001, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        kB = mk(32'h0a000041, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        kC = mk(32'h0a000003, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        kD = mk(32'h0a000081, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        // A,B,D hash to 33; C hashes to 35
        vt[0] = '{rq: 0, key: kA, hit: 1'b0, idx: 6'd0, lat: 1, nc: 7'd1};
        vt[1] = '{rq: 1, key: kA, hit: 1'b1, idx: 6'd0, lat: 1, nc: 7'd1};
        vt[2] = '{rq: 0, key: kB, hit: 1'b0, idx: 6'd1, lat: 2, nc: 7'd2};
        vt[3] = '{rq: 1, key: kB, hit: 1'b1, idx: 6'd1, lat: 2, nc: 7'd2};
        vt[4] = '{rq: 0, key: kC, hit: 1'b0, idx: 6'd2, lat: 1, nc: 7'd3};
        vt[5] = '{rq: 1, key: kD, hit: 1'b0, idx: 6'd3, lat: 4, nc: 7'd4};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_idx", 32'(rsp_idx), 0);
        chk("rst_hit", 32'(rsp_hit), 0);
        chk("rst_full", 32'(rsp_full), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_nconn", 32'(n_conn), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send(vt[i].rq, vt[i].key, lat, hit, idx, full, nc, rv);
            chk($sformatf("v%0d_hit", i), 32'(hit), 32'(vt[i].hit));
            chk($sformatf("v%0d_idx", i), 32'(idx), 32'(vt[i].idx));
            chk($sformatf("v%0d_full", i), 32'(full), 0);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_nconn", i), 32'(nc), 32'(vt[i].nc));
            chk($sformatf("v%0d_rspv", i), 32'(rv), 32'(1 << vt[i].rq));
        end

        // both requesters always valid: grants must alternate
        ng = 0;
        nk = 0;
        @(negedge clk);
        req_key[0 +: KW] = mk(32'h0b000000, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        req_key[KW +: KW] = mk(32'h0b100000, 32'h0a000002, 16'h1234, 16'h0050, 8'h06);
        req_valid = 2'b11;
        for (int c = 0; c < 300 && ng < 8; c++) begin
            #1;
            g = req_ready;
            if (g != '0) begin
                chk("t4_onehot", 32'($countones(g)), 1);
                gseq[ng] = g[1];
                ng++;
            end
            @(posedge clk);
            #1;
            if (g[0]) begin
                nk++;
                req_key[0 +: KW] = mk(32'h0b000000 + nk, 32'h0a000002,
                                      16'h1234, 16'h0050, 8'h06);
            end
            if (g[1]) begin
                nk++;
                req_key[KW +: KW] = mk(32'h0b100000 + nk, 32'h0a000002,
                                       16'h1234, 16'h0050, 8'h06);
            end
            @(negedge clk);
        end
        req_valid = '0;
        chk("t4_grants", 32'(ng), 8);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("t4_alt%0d", k), 32'(gseq[k]), 32'(!gseq[k-1]));
        end
        repeat (80) @(negedge clk);
        chk("t4_nconn", 32'(n_conn), 12);

        // flush requested while D is being probed
        @(negedge clk);
        req_valid = 2'b01;
        req_key = '0;
        req_key[0 +: KW] = kD;
        #1;
        chk("t6_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        clr_req = 1'b1;
        #1;
        chk("t6_busy_now", 32'(clr_busy), 1);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        lat = 1;
        hit = 1'bx;
        idx = 'x;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[0]) begin
                hit = rsp_hit;
                idx = rsp_idx;
                break;
            end
        end
        chk("t6_lat", 32'(lat), 4);
        chk("t6_hit", 32'(hit), 1);
        chk("t6_idx", 32'(idx), 3);
        @(negedge clk);
        n = 1;
        chk("t6_hold_idx", 32'(rsp_idx), 3);
        chk("t6_hold_hit", 32'(rsp_hit), 1);
        chk("t6_busy_after", 32'(clr_busy), 1);
        while (clr_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t6_clear_cycles", 32'(n), 66);
        chk("t6_nconn", 32'(n_conn), 0);
        send(1, kA, lat, hit, idx, full, nc, rv);
        chk("t6_reins_hit", 32'(hit), 0);
        chk("t6_reins_idx", 32'(idx), 0);
        chk("t6_reins_lat", 32'(lat), 1);

        // fill the table, then overflow it
        for (int i = 1; i < 64; i++) begin
            send(i % 2, mk(32'h0c000000 + i, 32'h0a000002, 16'h1234,
                           16'h0050, 8'h06), lat, hit, idx, full, nc, rv);
            chk($sformatf("t5_fill%0d_idx", i), 32'(idx), i);
            chk($sformatf("t5_fill%0d_hit", i), 32'(hit), 0);
        end
        chk("t5_nconn_full", 32'(nc), 64);
        send(0, mk(32'h0d000000, 32'h0a000002, 16'h1234, 16'h0050, 8'h06),
             lat, hit, idx, full, nc, rv);
        chk("t5_ovf_full", 32'(full), 1);
        chk("t5_ovf_hit", 32'(hit), 0);
        chk("t5_ovf_idx", 32'(idx), 0);
        chk("t5_ovf_lat", 32'(lat), 64);
        chk("t5_ovf_nconn", 32'(nc), 64);
        send(1, kA, lat, hit, idx, full, nc, rv);
        chk("t5_lookA_hit", 32'(hit), 1);
        chk("t5_lookA_idx", 32'(idx), 0);
        chk("t5_lookA_full", 32'(full), 0);

        // clear beats a simultaneous request, then reset mid-flush
        @(negedge clk);
        clr_req = 1'b1;
        req_valid = 2'b01;
        req_key = '0;
        req_key[0 +: KW] = kB;
        #1;
        chk("t7_clr_wins", 32'(req_ready), 0);
        chk("t7_busy", 32'(clr_busy), 1);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        req_valid = '0;
        repeat (10) @(negedge clk);
        #1;
        chk("t7_in_clear", 32'(clr_busy), 1);
        chk("t7_nconn_mid", 32'(n_conn), 64);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("t7_rst_ready", 32'(req_ready), 0);
        chk("t7_rst_rspv", 32'(rsp_valid), 0);
        chk("t7_rst_idx", 32'(rsp_idx), 0);
        chk("t7_rst_hit", 32'(rsp_hit), 0);
        chk("t7_rst_full", 32'(rsp_full), 0);
        chk("t7_rst_busy", 32'(clr_busy), 0);
        chk("t7_rst_nconn", 32'(n_conn), 0);
        @(negedge clk);
        reset = 1'b1;
        send(0, kB, lat, hit, idx, full, nc, rv);
        chk("t7_post_hit", 32'(hit), 0);
        chk("t7_post_idx", 32'(idx), 0);
        chk("t7_post_lat", 32'(lat), 1);
        chk("t7_post_nconn", 32'(nc), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
